// File: rtl/signed_div8by4.sv
// rtl/signed_div8by4.sv - sequential 8-by-4 signed restoring divider
//
// Purpose: divides an 8-bit signed dividend by a 4-bit signed divisor using
// magnitudes and a restoring algorithm. It resolves one quotient bit per
// clock. Signs are applied in a final fix-up cycle.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   start     in   1  request, sampled only while idle
//   dividend  in   8  signed dividend
//   divisor   in   4  signed divisor
//   busy      out  1  division in progress
//   done      out  1  one-cycle pulse, results valid
//   q         out  8  signed quotient (truncated toward zero)
//   r         out  4  signed remainder (sign of dividend)
//   dz        out  1  divide-by-zero flag for last result
//   ovf       out  1  overflow flag for last result (-128 / -1)

module signed_div8by4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] q,
  output logic [3:0] r,
  output logic       dz,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  // Dividend magnitude shifts out of the top while quotient bits shift in
  // at the bottom; after eight iterations it holds the quotient magnitude.
  logic [7:0] dvd_q;
  logic [4:0] prem;
  logic [3:0] dvs_mag;
  logic       dvd_neg, q_neg, dz_pend, ovf_pend;

  logic [7:0] dvd_mag_in;
  logic [3:0] dvs_mag_in;
  logic [5:0] shifted;
  logic       ge;
  logic [4:0] prem_nxt;

  // 128 is representable as an unsigned 8-bit magnitude, so -128 needs no
  // extra bit here.
  assign dvd_mag_in = dividend[7] ? 8'd0 - dividend : dividend;
  assign dvs_mag_in = divisor[3]  ? 4'd0 - divisor  : divisor;

  // One restoring step. When the trial subtraction succeeds the difference
  // is smaller than the divisor magnitude, so five bits hold it exactly.
  assign shifted  = {prem, dvd_q[7]};
  assign ge       = shifted >= {2'b00, dvs_mag};
  assign prem_nxt = ge ? (shifted[4:0] - {1'b0, dvs_mag}) : shifted[4:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == 4'd7) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      dvd_q    <= 8'd0;
      prem     <= 5'd0;
      dvs_mag  <= 4'd0;
      dvd_neg  <= 1'b0;
      q_neg    <= 1'b0;
      dz_pend  <= 1'b0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= 8'd0;
      r        <= 4'd0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= 4'd0;
            dvd_q    <= dvd_mag_in;
            prem     <= 5'd0;
            dvs_mag  <= dvs_mag_in;
            dvd_neg  <= dividend[7];
            q_neg    <= dividend[7] ^ divisor[3];
            dz_pend  <= (divisor == 4'h0);
            ovf_pend <= (dividend == 8'h80) && (divisor == 4'hF);
          end
        end
        CALC: begin
          cnt   <= cnt + 4'd1;
          prem  <= prem_nxt;
          dvd_q <= {dvd_q[6:0], ge};
        end
        FIX: begin
          // A zero divisor lets every trial succeed, so the magnitudes are
          // meaningless and the result is forced to zero.
          if (dz_pend) begin
            q <= 8'd0;
            r <= 4'd0;
          end else begin
            q <= q_neg   ? 8'd0 - dvd_q     : dvd_q;
            r <= dvd_neg ? 4'd0 - prem[3:0] : prem[3:0];
          end
          dz  <= dz_pend;
          ovf <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div8by4.sv
// tb/tb_signed_div8by4.sv - self-checking bench for signed_div8by4

module tb_signed_div8by4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done, dz, ovf;
  logic [7:0] q;
  logic [3:0] r;

  int tests  = 0;
  int failed = 0;

  signed_div8by4 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .dz       (dz),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division truncates toward zero and the
  // remainder takes the sign of the dividend.
  function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                output logic [7:0] eq, output logic [3:0] er,
                                output logic edz, output logic eovf);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    edz = 1'b0; eovf = 1'b0;
    if (sb == 0) begin
      eq = 8'h00; er = 4'h0; edz = 1'b1;
    end else if (sa == -128 && sb == -1) begin
      eq = 8'h80; er = 4'h0; eovf = 1'b1;
    end else begin
      eq = 8'(sa / sb);
      er = 4'(sa % sb);
    end
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Launches one division and returns after the negedge where done is high.
  task automatic do_div(input logic [7:0] a, input logic [3:0] b, output int lat);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
  endtask

  task automatic check_result(input string tag, input logic [7:0] a, input logic [3:0] b);
    logic [7:0] eq; logic [3:0] er; logic edz, eovf;
    int sa, sb, qi, ri;
    model(a, b, eq, er, edz, eovf);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".res"}, {16'd0, q, r, 2'b00, dz, ovf}, {16'd0, eq, er, 2'b00, edz, eovf});
    if (!edz && !eovf) begin
      sa = int'($signed(a)); sb = int'($signed(b));
      qi = int'($signed(q)); ri = int'($signed(r));
      check({tag, ".ident"}, 32'(qi * sb + ri), 32'(sa));
      check({tag, ".rbound"}, 32'((ri < 0 ? -ri : ri) < (sb < 0 ? -sb : sb)), 32'd1);
    end
  endtask

  typedef struct { logic [7:0] a; logic [3:0] b; } pair_t;

  initial begin
    pair_t dir[6];
    int lat, n, done_seen;
    logic [7:0] a; logic [3:0] b;

    dir[0] = '{8'hD6, 4'h6}; dir[1] = '{8'h23, 4'h8}; dir[2] = '{8'hDB, 4'h5};
    dir[3] = '{8'h80, 4'hF}; dir[4] = '{8'h80, 4'h8}; dir[5] = '{8'h64, 4'h0};

    rst_n = 1'b0; start = 1'b0; dividend = 8'h00; divisor = 4'h0;
    repeat (3) @(negedge clk);
    check("rst.outs", {22'd0, busy, done, q, r, dz, ovf}, 32'd0);
    rst_n = 1'b1;

    // Directed cases, including the spec examples as explicit constants.
    foreach (dir[i]) begin
      do_div(dir[i].a, dir[i].b, lat);
      check($sformatf("dir%0d.lat", i), 32'(lat), 32'd9);
      check_result($sformatf("dir%0d", i), dir[i].a, dir[i].b);
    end
    do_div(8'hDB, 4'h5, lat);
    check("ex.qr", {24'd0, q, 4'h0 | r[3:0] & 4'hF} >> 0, {24'd0, 8'hF9, 4'hE} >> 0);
    check("busy_done_excl", 32'(busy), 32'd0);

    // Results hold while the next division runs; inputs change mid-CALC.
    @(negedge clk);
    dividend = 8'hD6; divisor = 4'h6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold.busy", 32'(busy), 32'd1);
    check("hold.q", {24'd0, q}, 32'hF9);
    repeat (2) @(negedge clk);
    dividend = 8'h11; divisor = 4'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("midcalc.lat", 32'(lat + 3), 32'd9);
    check_result("midcalc", 8'hD6, 4'h6);

    // Back-to-back: start during the done cycle.
    dividend = 8'h23; divisor = 4'h8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("b2b.gap", 32'(lat + 1), 32'd10);
    check_result("b2b", 8'h23, 4'h8);

    // Reset asserted at E4 aborts without a done pulse.
    @(negedge clk);
    dividend = 8'h64; divisor = 4'h3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_mid.outs", {22'd0, busy, done, q, r, dz, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("rst_mid.nodone", 32'(done_seen), 32'd0);
    do_div(8'h64, 4'h3, lat);
    check("post_rst.lat", 32'(lat), 32'd9);
    check_result("post_rst", 8'h64, 4'h3);

    // Randomized operands with random idle gaps.
    for (int k = 0; k < 200; k++) begin
      a = 8'($urandom); b = 4'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_div(a, b, lat);
      check("rnd.lat", 32'(lat), 32'd9);
      check_result("rnd", a, b);
    end

    // Exhaustive sweep.
    n = 0;
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        do_div(8'(ia), 4'(ib), lat);
        if (lat != 9) check("sweep.lat", 32'(lat), 32'd9);
        check_result("sweep", 8'(ia), 4'(ib));
        n++;
      end
    end
    check("sweep.count", 32'(n), 32'd4096);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
